// File: rtl/floor_scheduler.sv
// -----------------------------------------------------------------------------
// floor_scheduler
//
// Purpose:
//   Latches interior (cabin) and exterior (hall) floor calls into a pending mask
//   and chooses the next target floor with a SCAN (keep-direction) policy. It
//   also times the door dwell at each served floor. Interior calls are accepted
//   only while management is logged in.
//
// Ports:
//   clk_i            in   1       system clock, rising edge
//   rst_ni           in   1       asynchronous reset, active-low
//   logged_in_i      in   1       management login; 0 = interior_req_i ignored
//   interior_req_i   in   FLOORS  cabin buttons, level, one bit per floor
//   exterior_req_i   in   FLOORS  hall buttons, level, one bit per floor
//   cur_floor_i      in   FW      floor the cabin is at / last passed
//   arrived_i        in   1       1-cycle pulse: cabin stopped at cur_floor_i
//   target_floor_o   out  FW      floor movement must drive to (when valid)
//   target_valid_o   out  1       request to movement, held until arrival
//   dir_up_o         out  1       current sweep direction, 1 = up
//   door_hold_o      out  1       1 during dwell; doors must stay open
//   pending_o        out  FLOORS  registered mask of unserved calls
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module floor_scheduler #(
    parameter int FLOORS       = 3,
    parameter int FW           = 2,
    parameter int DWELL_CYCLES = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              logged_in_i,
    input  logic [FLOORS-1:0] interior_req_i,
    input  logic [FLOORS-1:0] exterior_req_i,
    input  logic [FW-1:0]     cur_floor_i,
    input  logic              arrived_i,
    output logic [FW-1:0]     target_floor_o,
    output logic              target_valid_o,
    output logic              dir_up_o,
    output logic              door_hold_o,
    output logic [FLOORS-1:0] pending_o
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DWELL     = 2'd3
    } state_e;

    state_e            state_q,   state_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [FW-1:0]     target_q,  target_d;
    logic              valid_q,   valid_d;
    logic              dir_q,     dir_d;
    logic              door_q,    door_d;
    logic [CW-1:0]     cnt_q,     cnt_d;

    logic [FLOORS-1:0] set_s;
    logic [FLOORS-1:0] cur_mask_s;
    logic              up_found_s;
    logic [FW-1:0]     up_idx_s;
    logic              dn_found_s;
    logic [FW-1:0]     dn_idx_s;
    logic              here_s;
    logic              cur_call_s;
    logic              arrive_hit_s;
    logic              ahead_s;
    logic              behind_s;

    // New calls this cycle and a one-hot mask of the cabin's floor.
    // A cur_floor_i beyond the last floor yields an empty mask.
    always_comb begin
        set_s      = exterior_req_i | (interior_req_i & {FLOORS{logged_in_i}});
        cur_mask_s = {FLOORS{1'b0}};
        for (int i = 0; i < FLOORS; i++) begin
            cur_mask_s[i] = (i == int'(cur_floor_i));
        end
    end

    // Nearest pending floor above (lowest) and below (highest) the cabin.
    // The upward scan runs top-down so the last hit is the nearest one;
    // the downward scan runs bottom-up for the same reason.
    always_comb begin
        up_found_s = 1'b0;
        up_idx_s   = {FW{1'b0}};
        dn_found_s = 1'b0;
        dn_idx_s   = {FW{1'b0}};
        for (int i = FLOORS - 1; i >= 0; i--) begin
            up_idx_s   = (pending_q[i] && (i > int'(cur_floor_i))) ? i[FW-1:0] : up_idx_s;
            up_found_s = up_found_s | (pending_q[i] && (i > int'(cur_floor_i)));
        end
        for (int i = 0; i < FLOORS; i++) begin
            dn_idx_s   = (pending_q[i] && (i < int'(cur_floor_i))) ? i[FW-1:0] : dn_idx_s;
            dn_found_s = dn_found_s | (pending_q[i] && (i < int'(cur_floor_i)));
        end
    end

    // Qualifiers shared by the FSM.
    always_comb begin
        here_s       = |(pending_q & cur_mask_s);
        cur_call_s   = |(set_s & cur_mask_s);
        arrive_hit_s = arrived_i & valid_q & (cur_floor_i == target_q);
        ahead_s      = dir_q ? up_found_s : dn_found_s;
        behind_s     = dir_q ? dn_found_s : up_found_s;
    end

    // Next-state, call mask, target and dwell-counter logic.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | set_s;
        target_d  = target_q;
        valid_d   = valid_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (here_s) begin
                    // Call at the cabin's own floor: open doors, no trip.
                    state_d   = ST_DWELL;
                    pending_d = pending_d & ~cur_mask_s;
                    cnt_d     = {CW{1'b0}};
                end else if (up_found_s) begin
                    state_d = ST_MOVE_UP;
                    dir_d   = 1'b1;
                end else if (dn_found_s) begin
                    state_d = ST_MOVE_DOWN;
                    dir_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (arrive_hit_s) begin
                    // Clearing the served floor overrides a same-cycle press.
                    valid_d   = 1'b0;
                    pending_d = pending_d & ~cur_mask_s;
                    state_d   = ST_DWELL;
                    cnt_d     = {CW{1'b0}};
                end else if (state_q == ST_MOVE_UP) begin
                    // Re-evaluated each cycle so a nearer call pre-empts.
                    // When the cabin already reports the target floor but has
                    // not pulsed arrived, nothing lies above: keep the target.
                    valid_d  = valid_q | up_found_s;
                    target_d = up_found_s ? up_idx_s : target_q;
                end else begin
                    valid_d  = valid_q | dn_found_s;
                    target_d = dn_found_s ? dn_idx_s : target_q;
                end
            end

            ST_DWELL: begin
                valid_d   = 1'b0;
                // A press at the open floor is not latched; it restarts dwell.
                pending_d = pending_q | (set_s & ~cur_mask_s);
                if (cur_call_s) begin
                    cnt_d = {CW{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (ahead_s) begin
                        state_d = dir_q ? ST_MOVE_UP : ST_MOVE_DOWN;
                    end else if (behind_s) begin
                        state_d = dir_q ? ST_MOVE_DOWN : ST_MOVE_UP;
                        dir_d   = ~dir_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Door output follows the next state so it is high exactly while in DWELL.
    always_comb begin
        door_d = (state_d == ST_DWELL);
    end

    // State and output registers; reset discards all calls at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            pending_q <= {FLOORS{1'b0}};
            target_q  <= {FW{1'b0}};
            valid_q   <= 1'b0;
            dir_q     <= 1'b1;
            door_q    <= 1'b0;
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            valid_q   <= valid_d;
            dir_q     <= dir_d;
            door_q    <= door_d;
            cnt_q     <= cnt_d;
        end
    end

    assign target_floor_o = target_q;
    assign target_valid_o = valid_q;
    assign dir_up_o       = dir_q;
    assign door_hold_o    = door_q;
    assign pending_o      = pending_q;

endmodule

// File: tb/tb_floor_scheduler.sv
// -----------------------------------------------------------------------------
// tb_floor_scheduler
//
// Directed stimulus pushes expected events (new target requests, completed
// dwells with their length) and expected per-cycle output probes into queues;
// a separate monitor on the falling clock edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_floor_scheduler;

    localparam int FLOORS = 3;
    localparam int FW     = 2;
    localparam int DWELL  = 8;

    localparam int K_TGT   = 0;
    localparam int K_DWELL = 1;

    localparam int P_PEND  = 0;
    localparam int P_TGT   = 1;
    localparam int P_VALID = 2;
    localparam int P_DIR   = 3;
    localparam int P_DOOR  = 4;

    typedef struct {
        int kind;
        int floor;
        int dir;
        int len;
    } ev_t;

    typedef struct {
        int    sel;
        int    expv;
        string nm;
    } probe_t;

    logic              clk;
    logic              rst_n;
    logic              logged_in;
    logic [FLOORS-1:0] interior_req;
    logic [FLOORS-1:0] exterior_req;
    logic [FW-1:0]     cur_floor;
    logic              arrived;
    logic [FW-1:0]     target_floor;
    logic              target_valid;
    logic              dir_up;
    logic              door_hold;
    logic [FLOORS-1:0] pending;

    ev_t    sb[$];
    probe_t pq[$];
    int     errors = 0;
    int     checks = 0;
    logic   done   = 1'b0;

    floor_scheduler #(
        .FLOORS       (FLOORS),
        .FW           (FW),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .logged_in_i    (logged_in),
        .interior_req_i (interior_req),
        .exterior_req_i (exterior_req),
        .cur_floor_i    (cur_floor),
        .arrived_i      (arrived),
        .target_floor_o (target_floor),
        .target_valid_o (target_valid),
        .dir_up_o       (dir_up),
        .door_hold_o    (door_hold),
        .pending_o      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking (monitor process only) ----------------
    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    initial begin : monitor
        probe_t pr;
        ev_t    ev;
        int     act;
        logic   prev_valid = 1'b0;
        logic [FW-1:0] prev_tgt = '0;
        logic   prev_door = 1'b0;
        int     door_len = 0;
        int     dwell_floor = 0;
        forever begin
            @(negedge clk);
            while (pq.size() != 0) begin
                pr = pq.pop_front();
                case (pr.sel)
                    P_PEND:  act = int'(pending);
                    P_TGT:   act = int'(target_floor);
                    P_VALID: act = int'(target_valid);
                    P_DIR:   act = int'(dir_up);
                    P_DOOR:  act = int'(door_hold);
                    default: act = -1;
                endcase
                chk(pr.nm, act, pr.expv);
            end
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_tgt   = '0;
                prev_door  = 1'b0;
                door_len   = 0;
            end else begin
                if (target_valid && (!prev_valid || target_floor != prev_tgt)) begin
                    chk("tgt_event_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        ev = sb.pop_front();
                        chk("tgt_kind", ev.kind, K_TGT);
                        chk("tgt_floor", int'(target_floor), ev.floor);
                        chk("tgt_dir", int'(dir_up), ev.dir);
                        chk("tgt_in_range", int'(int'(target_floor) < FLOORS), 1);
                    end
                end
                if (door_hold) begin
                    if (!prev_door) dwell_floor = int'(cur_floor);
                    door_len++;
                end else if (prev_door) begin
                    chk("dwell_event_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        ev = sb.pop_front();
                        chk("dwell_kind", ev.kind, K_DWELL);
                        chk("dwell_floor", dwell_floor, ev.floor);
                        chk("dwell_len", door_len, ev.len);
                    end
                    door_len = 0;
                end
                prev_valid = target_valid;
                prev_tgt   = target_floor;
                prev_door  = door_hold;
            end
            if (done) begin
                chk("sb_drained", sb.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int sel, input int expv, input string nm);
        probe_t p;
        p.sel = sel; p.expv = expv; p.nm = nm;
        pq.push_back(p);
    endtask

    task automatic exp_tgt(input int fl, input int dr);
        ev_t e;
        e.kind = K_TGT; e.floor = fl; e.dir = dr; e.len = 0;
        sb.push_back(e);
    endtask

    task automatic exp_dwell(input int fl, input int ln);
        ev_t e;
        e.kind = K_DWELL; e.floor = fl; e.dir = 0; e.len = ln;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int fl);
        step(1);
        rst_n        = 1'b0;
        logged_in    = 1'b1;
        interior_req = '0;
        exterior_req = '0;
        arrived      = 1'b0;
        cur_floor    = FW'(fl);
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        rst_n        = 1'b0;
        logged_in    = 1'b1;
        interior_req = '0;
        exterior_req = '0;
        cur_floor    = '0;
        arrived      = 1'b0;
        step(1);
        probe(P_PEND,  0, "rst0_pend");
        probe(P_VALID, 0, "rst0_valid");
        probe(P_DIR,   1, "rst0_dir");
        probe(P_DOOR,  0, "rst0_door");
        step(1);
        rst_n = 1'b1;
        step(1);

        // Async reset mid-MOVE_UP with pending = 110.
        exp_tgt(1, 1);
        exterior_req = 3'b110; step(1); exterior_req = 3'b000;
        probe(P_PEND, 6, "s1_pend_latched");
        step(2);
        probe(P_VALID, 1, "s1_valid");
        probe(P_TGT,   1, "s1_tgt_lowest_above");
        step(1);
        #2 rst_n = 1'b0;
        #1;
        probe(P_PEND,  0, "s1_rst_pend");
        probe(P_VALID, 0, "s1_rst_valid");
        probe(P_TGT,   0, "s1_rst_tgt");
        probe(P_DIR,   1, "s1_rst_dir");
        probe(P_DOOR,  0, "s1_rst_door");
        #3 rst_n = 1'b1;
        step(1);

        // Simple trip 0 -> 2, with a mismatched arrival ignored.
        do_reset(0);
        exp_tgt(2, 1);
        exp_dwell(2, DWELL);
        exterior_req = 3'b100; step(1); exterior_req = 3'b000;
        probe(P_PEND, 4, "s2_pend");
        step(2);
        probe(P_TGT, 2, "s2_tgt"); probe(P_VALID, 1, "s2_valid"); probe(P_DIR, 1, "s2_dir");
        cur_floor = 2'd1; arrived = 1'b1; step(1); arrived = 1'b0;
        probe(P_VALID, 1, "s2_mismatch_valid"); probe(P_DOOR, 0, "s2_mismatch_door");
        cur_floor = 2'd2; arrived = 1'b1; step(1); arrived = 1'b0;
        probe(P_DOOR, 1, "s2_door"); probe(P_VALID, 0, "s2_valid_drop"); probe(P_PEND, 0, "s2_pend_clr");
        step(DWELL);
        probe(P_DOOR, 0, "s2_door_end"); probe(P_PEND, 0, "s2_pend_end");

        // Pre-emption: heading to 2, a call at 1 is served first.
        do_reset(0);
        exp_tgt(2, 1);
        exterior_req = 3'b100; step(1); exterior_req = 3'b000;
        step(2);
        probe(P_TGT, 2, "s3_tgt2");
        exp_tgt(1, 1); exp_dwell(1, DWELL); exp_tgt(2, 1); exp_dwell(2, DWELL);
        exterior_req = 3'b010; step(1); exterior_req = 3'b000;
        probe(P_PEND, 6, "s3_pend"); probe(P_TGT, 2, "s3_tgt_before");
        step(1);
        probe(P_TGT, 1, "s3_tgt_preempt");
        cur_floor = 2'd1; arrived = 1'b1; step(1); arrived = 1'b0;
        probe(P_PEND, 4, "s3_pend_after1"); probe(P_DOOR, 1, "s3_door1");
        step(DWELL);
        probe(P_DOOR, 0, "s3_door1_end");
        step(1);
        probe(P_TGT, 2, "s3_resume"); probe(P_VALID, 1, "s3_resume_valid");
        cur_floor = 2'd2; arrived = 1'b1; step(1); arrived = 1'b0;
        step(DWELL);
        probe(P_PEND, 0, "s3_pend_end");

        // Login gate on interior calls; logout keeps latched calls.
        do_reset(0);
        logged_in = 1'b0; interior_req = 3'b010;
        step(2);
        probe(P_PEND, 0, "s4_gated");
        exp_tgt(1, 1);
        logged_in = 1'b1; step(1);
        probe(P_PEND, 2, "s4_login");
        logged_in = 1'b0; interior_req = 3'b000; step(1);
        probe(P_PEND, 2, "s4_logout_keeps");
        step(1);
        probe(P_TGT, 1, "s4_tgt");

        // SCAN reversal: at 1 with calls at 0 and 2 -> 2 first, then 0.
        do_reset(1);
        exp_tgt(2, 1); exp_dwell(2, DWELL); exp_tgt(0, 0); exp_dwell(0, DWELL);
        exterior_req = 3'b101; step(1); exterior_req = 3'b000;
        probe(P_PEND, 5, "s5_pend");
        step(2);
        probe(P_TGT, 2, "s5_tgt_up"); probe(P_DIR, 1, "s5_dir_up");
        cur_floor = 2'd2; arrived = 1'b1; step(1); arrived = 1'b0;
        probe(P_PEND, 1, "s5_pend_after2"); probe(P_DOOR, 1, "s5_door2");
        step(DWELL);
        probe(P_DIR, 0, "s5_reversed"); probe(P_DOOR, 0, "s5_door2_end");
        step(1);
        probe(P_TGT, 0, "s5_tgt_down"); probe(P_VALID, 1, "s5_valid_down");
        cur_floor = 2'd0; arrived = 1'b1; step(1); arrived = 1'b0;
        step(DWELL);
        probe(P_PEND, 0, "s5_pend_end"); probe(P_DOOR, 0, "s5_door_end"); probe(P_DIR, 0, "s5_dir_idle");

        // Same floor: dwell without a trip; re-press restarts the dwell.
        do_reset(1);
        exp_dwell(1, 4 + DWELL);
        exterior_req = 3'b010; step(1); exterior_req = 3'b000;
        probe(P_PEND, 2, "s6_pend");
        step(1);
        probe(P_DOOR, 1, "s6_door"); probe(P_VALID, 0, "s6_no_valid"); probe(P_PEND, 0, "s6_pend_clr");
        step(3);
        exterior_req = 3'b010; step(1); exterior_req = 3'b000;
        probe(P_PEND, 0, "s6_repress_not_latched"); probe(P_DOOR, 1, "s6_door_ext");
        step(DWELL - 1);
        probe(P_DOOR, 1, "s6_door_still");
        step(1);
        probe(P_DOOR, 0, "s6_door_end"); probe(P_VALID, 0, "s6_valid_end"); probe(P_PEND, 0, "s6_pend_end");

        step(2);
        done = 1'b1;
    end

endmodule
